perceptron_activation: RTL and testbench
========================================

# perceptron_activation

Downstream stage of the perceptron datapath. It consumes the perceptron's 8-bit signed sum and accumulates a fixed window of ACC_LEN sums. It then adds a signed bias, applies a threshold to produce a 1-bit fire decision, and presents the result on a valid/ready output port. The block converts the perceptron's free-running per-cycle sum into discrete, back-pressurable decisions for the output pins and any following layer.

## Interface
- `ACC_LEN`, default 4: number of accepted sums per decision window; legal range 1..16.
- `THRESHOLD`, default 0: signed 8-bit; the block fires when the biased accumulator is greater than or equal to THRESHOLD.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (low) immediately clears all state. Release is synchronised by the integrator.
- `in_valid`  in  1  `in_sum` holds a sample this cycle.
- `in_sum`  in  8  perceptron sum, two's complement.
- `in_ready`  out  1  block accepts a sample this cycle.
- `bias`  in  8  signed bias; sampled in DECIDE only.
- `out_valid`  out  1  a decision is held on `out_acc` and `out_fire`.
- `out_ready`  in  1  consumer takes the decision.
- `out_acc`  out  12  saturated sum of the window plus bias, signed.
- `out_fire`  out  1  1 when `out_acc` is greater than or equal to THRESHOLD.
- `drop`  out  1  sticky flag: a sample was offered while `in_ready` was 0.

## Operation
- Reset values: state=ACCUM, acc=0, cnt=0, out_valid=0, out_acc=0, out_fire=0, drop=0.
- FSM states and transitions:
  - ACCUM → DECIDE on the accept that makes cnt reach ACC_LEN.
  - DECIDE → HOLD unconditionally.
  - HOLD → ACCUM on the out_valid && out_ready handshake.
- `in_ready` = (state==ACCUM); it is a combinational decode of the state register only.
- Accept = in_valid && in_ready. On accept, acc += sign_extend(in_sum) and cnt += 1.
- Accumulator width and overflow:
  - acc is 12-bit signed.
  - The range is bounded by 16×[−128,127] = [−2048,2032], so acc cannot overflow and needs no check.
- DECIDE:
  - Compute sum13 = sign_ext(acc) + sign_ext(bias) at 13 bits.
  - Saturate sum13 to [−2048, 2047] and register the result into out_acc.
  - out_fire = (saturated value ≥ sign_ext(THRESHOLD)).
  - Set out_valid=1.
- HOLD:
  - out_valid, out_acc and out_fire stay stable until the handshake.
  - On the handshake: out_valid←0, acc←0, cnt←0. out_acc and out_fire keep their last values.
- `drop` is set on any cycle with in_valid && !in_ready. It is cleared only by reset, and the offered sample is discarded.
- Reset asserted mid-window clears acc, cnt, outputs and the FSM at once. Partial sums are discarded.

## Timing
- Samples are accepted on every cycle while in ACCUM; the block has no input bubbles.
- Edge k is the edge with the final accept. DECIDE is occupied during cycle k+1. out_valid is high after edge k+1.
- Latency from final accept to out_valid is 2 edges.
- Handshake at edge h: out_valid is low and in_ready is high after edge h. A sample can be accepted at edge h+1.
- The first-sample-to-next-first-sample period is ACC_LEN+2 cycles when out_ready is held high.
- out_ready is ignored when out_valid=0.
- With ACC_LEN=1, every accept goes directly to DECIDE.

## Structure
- Shared package `perceptron_pkg` holds:
  - the state enum {ACCUM, DECIDE, HOLD};
  - the constants SUM_W=8 and ACC_W=12;
  - a `sat13to12` function.
- Everything is in a single module. No sub-module is warranted: the datapath is one adder, one saturator and one comparator.

## Test plan
- Reset and idle:
  - Hold reset low mid-run, then release it.
  - Required response: out_valid=0, out_acc=0, out_fire=0, drop=0 and in_ready=1 the cycle after release.
- Basic window (ACC_LEN=4, THRESHOLD=0, bias=0):
  - Sums 3, −1, 2, 4 on consecutive cycles.
  - Required response: out_valid rises 2 edges after the 4th accept, with out_acc=8 and out_fire=1.
- Negative window with bias:
  - Sums −8 ×4 with bias=5.
  - Required response: out_acc=−27, out_fire=0.
  - Change bias to −100 while in HOLD; out_acc stays at −27.
- Saturation (ACC_LEN=16, THRESHOLD=127):
  - Sum 127 ×16 with bias=127.
  - Required response: out_acc=2047, out_fire=1.
  - Then sum −128 ×16 with bias=−128: out_acc=−2048, out_fire=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with sum=50.
  - Required response: out_acc and out_fire are stable, in_ready=0 and drop=1.
  - After the handshake, a fresh window of 1,1,1,1 yields out_acc=4 with no leftover contribution from the dropped samples.
- Reset mid-window:
  - Assert reset after 2 accepts (5, 5), then send sums 1,1,1,1.
  - Required response: out_acc=4, not 14.

Source files
------------

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types, widths and saturation helper for the perceptron datapath
package perceptron_pkg;

  localparam int SUM_W = 8;
  localparam int ACC_W = 12;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DECIDE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Clamp a 13-bit signed value into the 12-bit signed range [-2048, 2047].
  function automatic logic signed [ACC_W-1:0] sat13to12(input logic signed [ACC_W:0] v);
    if (v > $signed(13'h07FF))
      return $signed(12'h7FF);
    else if (v < $signed(13'h1800))
      return $signed(12'h800);
    else
      return v[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/perceptron_activation.sv
// rtl/perceptron_activation.sv - windowed accumulate, bias, saturate and threshold with valid/ready output
module perceptron_activation
  import perceptron_pkg::*;
#(
  parameter int               ACC_LEN   = 4,
  parameter logic signed [7:0] THRESHOLD = 8'sd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [SUM_W-1:0]        in_sum,
  output logic                    in_ready,
  input  logic [SUM_W-1:0]        bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_fire,
  output logic                    drop
);

  localparam logic [4:0] LAST_CNT = 5'(ACC_LEN - 1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic [4:0]               cnt_q;
  logic                     accept;
  logic                     handshake;
  logic signed [ACC_W:0]    sum13;
  logic signed [ACC_W-1:0]  sat_sum;
  logic signed [ACC_W-1:0]  thr12;

  // Input is only open while collecting a window; decode of the state register alone.
  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Bias is added at 13 bits so the saturator sees the true sum before clamping.
  assign sum13   = $signed({acc_q[ACC_W-1], acc_q}) + $signed({{(ACC_W+1-SUM_W){bias[SUM_W-1]}}, bias});
  assign sat_sum = sat13to12(sum13);
  assign thr12   = $signed({{(ACC_W-SUM_W){THRESHOLD[7]}}, THRESHOLD});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state: close the window on the last accept, decide for one cycle, hold until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && (cnt_q == LAST_CNT)) state_d = DECIDE;
      DECIDE:  state_d = HOLD;
      HOLD:    if (handshake) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath: accumulate on accept, register the decision, clear the window on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_fire  <= 1'b0;
    end else begin
      if (accept) begin
        acc_q <= acc_q + $signed({{(ACC_W-SUM_W){in_sum[SUM_W-1]}}, in_sum});
        cnt_q <= cnt_q + 5'd1;
      end
      if (state_q == DECIDE) begin
        out_acc   <= sat_sum;
        out_fire  <= (sat_sum >= thr12);
        out_valid <= 1'b1;
      end
      if (state_q == HOLD && handshake) begin
        out_valid <= 1'b0;
        acc_q     <= '0;
        cnt_q     <= '0;
      end
    end
  end

  // Sticky record of any sample offered while the input was closed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     drop <= 1'b0;
    else if (in_valid && !in_ready) drop <= 1'b1;
  end

endmodule

// File: tb/tb_perceptron_activation.sv
// tb/tb_perceptron_activation.sv - directed self-checking bench for perceptron_activation
module tb_perceptron_activation;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        a_in_valid = 1'b0;
  logic [7:0]  a_in_sum = '0;
  logic        a_in_ready;
  logic [7:0]  a_bias = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [11:0] a_out_acc;
  logic        a_out_fire;
  logic        a_drop;

  logic        b_in_valid = 1'b0;
  logic [7:0]  b_in_sum = '0;
  logic        b_in_ready;
  logic [7:0]  b_bias = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [11:0] b_out_acc;
  logic        b_out_fire;
  logic        b_drop;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  perceptron_activation #(.ACC_LEN(4), .THRESHOLD(8'sd0)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_sum(a_in_sum), .in_ready(a_in_ready),
    .bias(a_bias), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_fire(a_out_fire), .drop(a_drop)
  );

  perceptron_activation #(.ACC_LEN(16), .THRESHOLD(8'sd127)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_sum(b_in_sum), .in_ready(b_in_ready),
    .bias(b_bias), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_fire(b_out_fire), .drop(b_drop)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] s);
    a_in_valid = 1'b1;
    a_in_sum   = s;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] s);
    b_in_valid = 1'b1;
    b_in_sum   = s;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic handshake_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic handshake_b();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  initial begin
    // Reset and idle, including a reset asserted after a partial window.
    repeat (3) tick();
    reset = 1'b1;
    send_a(8'd7);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_acc",   $signed(a_out_acc), 0);
    chk("rst_out_fire",  a_out_fire, 0);
    chk("rst_drop",      a_drop, 0);
    chk("rst_in_ready",  a_in_ready, 1);

    // Basic window 3,-1,2,4 -> 8, fires at threshold 0.
    a_bias = 8'd0;
    send_a(8'd3);
    send_a(8'hFF);
    send_a(8'd2);
    chk("basic_no_valid_mid", a_out_valid, 0);
    send_a(8'd4);
    chk("basic_decide_valid", a_out_valid, 0);
    chk("basic_decide_ready", a_in_ready, 0);
    tick();
    chk("basic_valid", a_out_valid, 1);
    chk("basic_acc",   $signed(a_out_acc), 8);
    chk("basic_fire",  a_out_fire, 1);
    handshake_a();
    chk("basic_hs_valid", a_out_valid, 0);
    chk("basic_hs_ready", a_in_ready, 1);
    chk("basic_hs_acc_kept", $signed(a_out_acc), 8);

    // Negative window -8 x4 with bias 5 -> -27, no fire; bias change in HOLD ignored.
    a_bias = 8'd5;
    repeat (4) send_a(8'hF8);
    tick();
    chk("neg_valid", a_out_valid, 1);
    chk("neg_acc",   $signed(a_out_acc), -27);
    chk("neg_fire",  a_out_fire, 0);
    a_bias = 8'h9C;
    tick();
    tick();
    chk("neg_hold_acc", $signed(a_out_acc), -27);
    chk("neg_drop",     a_drop, 0);
    handshake_a();

    // Backpressure: window 10 x4 -> 40, then 5 stalled cycles with offered samples of 50.
    a_bias = 8'd0;
    repeat (4) send_a(8'd10);
    tick();
    chk("bp_valid", a_out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i % 2 == 0);
      a_in_sum   = 8'd50;
      tick();
    end
    a_in_valid = 1'b0;
    chk("bp_acc_stable",  $signed(a_out_acc), 40);
    chk("bp_fire_stable", a_out_fire, 1);
    chk("bp_valid_held",  a_out_valid, 1);
    chk("bp_in_ready",    a_in_ready, 0);
    chk("bp_drop",        a_drop, 1);
    handshake_a();
    repeat (4) send_a(8'd1);
    tick();
    chk("bp_fresh_valid", a_out_valid, 1);
    chk("bp_fresh_acc",   $signed(a_out_acc), 4);
    chk("bp_drop_sticky", a_drop, 1);
    handshake_a();

    // Reset mid-window discards the partial 5+5.
    send_a(8'd5);
    send_a(8'd5);
    reset = 1'b0;
    #1;
    chk("midrst_drop_clear", a_drop, 0);
    chk("midrst_acc_clear",  $signed(a_out_acc), 0);
    tick();
    reset = 1'b1;
    tick();
    repeat (4) send_a(8'd1);
    tick();
    chk("midrst_valid", a_out_valid, 1);
    chk("midrst_acc",   $signed(a_out_acc), 4);

    // Saturation on the 16-deep instance with threshold 127.
    b_bias = 8'd127;
    repeat (16) send_b(8'd127);
    chk("sat_decide_ready", b_in_ready, 0);
    tick();
    chk("sat_hi_valid", b_out_valid, 1);
    chk("sat_hi_acc",   $signed(b_out_acc), 2047);
    chk("sat_hi_fire",  b_out_fire, 1);
    handshake_b();
    b_bias = 8'h80;
    repeat (16) send_b(8'h80);
    tick();
    chk("sat_lo_valid", b_out_valid, 1);
    chk("sat_lo_acc",   $signed(b_out_acc), -2048);
    chk("sat_lo_fire",  b_out_fire, 0);
    chk("sat_drop",     b_drop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
